rst_req_gen: RTL



---
 rtl/rst_req_pkg.sv | 17 +
 rtl/rst_req_timer.sv | 33 +++
 rtl/rst_req_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/rst_req_pkg.sv
// Shared types and sizing helpers for the reset-request initiator.
package rst_req_pkg;

  typedef enum logic [1:0] {
    WATCH   = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } rst_req_state_e;

  // Wide enough to hold the larger load value itself, since the timer counts N..1.
  function automatic int tmr_width(input int pulse_cycles, input int holdoff_cycles);
    int m;
    m = (pulse_cycles > holdoff_cycles) ? pulse_cycles : holdoff_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_req_timer.sv
// Loadable down-counter shared by the PULSE and HOLDOFF phases; done_o is
// registered and high during the last cycle of a loaded interval.
module rst_req_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic         done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= load_val_i;
      done_q <= (load_val_i == W'(1));
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == W'(2));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/rst_req_gen.sv
// Watchdog / software reset-request initiator: WATCH -> PULSE -> HOLDOFF.
// Define RST_REQ_GEN_CNT_EN to build the saturating pulse counter on rst_cnt_o.
module rst_req_gen
  import rst_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PULSE_CYCLES   = 8,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 kick_i,
  input  logic                 sw_req_i,
  input  logic                 clr_i,
  output logic                 rst_req_o,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] rst_cnt_o
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int TMR_W = tmr_width(PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  rst_req_state_e    state_q;
  logic [WD_W-1:0]   wd_q;
  logic              rst_req_q;
  logic              timeout_q;
  logic              busy_q;

  logic              wd_expire;
  logic              go;
  logic              tmr_done;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;

  assign wd_expire = (state_q == WATCH) && (wd_q == WD_MAX) && !kick_i;
  assign go        = (state_q == WATCH) && (sw_req_i || wd_expire);
  assign tmr_load  = go || ((state_q == PULSE) && tmr_done);
  assign tmr_val   = go ? TMR_W'(PULSE_CYCLES) : TMR_W'(HOLDOFF_CYCLES);

  rst_req_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WATCH;
      wd_q      <= '0;
      rst_req_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // A watchdog expiry wins over a simultaneous clear.
      if (wd_expire)  timeout_q <= 1'b1;
      else if (clr_i) timeout_q <= 1'b0;

      case (state_q)
        WATCH: begin
          if (go) begin
            state_q   <= PULSE;
            rst_req_q <= 1'b1;
            busy_q    <= 1'b1;
            wd_q      <= '0;
          end else begin
            wd_q <= kick_i ? '0 : wd_q + 1'b1;
          end
        end
        PULSE: begin
          if (tmr_done) begin
            state_q   <= HOLDOFF;
            rst_req_q <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (tmr_done) begin
            state_q <= WATCH;
            busy_q  <= 1'b0;
            wd_q    <= '0;
          end
        end
        default: begin
          state_q   <= WATCH;
          rst_req_q <= 1'b0;
          busy_q    <= 1'b0;
          wd_q      <= '0;
        end
      endcase
    end
  end

  assign rst_req_o = rst_req_q;
  assign timeout_o = timeout_q;
  assign busy_o    = busy_q;

`ifdef RST_REQ_GEN_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                cnt_q <= '0;
    else if (go && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign rst_cnt_o = cnt_q;
`else
  assign rst_cnt_o = '0;
`endif

endmodule
